clk_ctrl: RTL and testbench

- Parametrised successor to the fixed 1 Hz divider and periodic CPU reset pulser in the board top level.
- Generates a single-cycle clock-enable strobe (ce) from the board clock, replacing the derived clock. Divide ratio is runtime-loadable.
- Adds run/single-step/halt modes.
- Generates a CPU reset pulse of configurable width, repeating at a configurable ce-tick period or firing once.
- Sits between the board clock and the CPU core; the CPU's ce/R inputs and the LED debug outputs are driven from here.

---
 rtl/clk_ctrl_pkg.sv | 23 ++
 rtl/clk_ctrl_if.sv | 24 ++
 rtl/ce_div.sv | 37 +++
 rtl/clk_ctrl.sv | 94 +++++++++
 tb/tb_clk_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared constants and elaboration-time legality checks for clk_ctrl.
package clk_ctrl_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  // Reset pulse must last at least one tick and leave room for a low phase in a loop.
  function automatic bit res_cfg_ok(int unsigned period, int unsigned width);
    if (width < 1) return 1'b0;
    if (period > 0 && width >= period) return 1'b0;
    return 1'b1;
  endfunction

  // Largest tick_cnt value must be representable in loop_w bits.
  function automatic bit loop_fits(int unsigned loop_w, int unsigned period, int unsigned width);
    longint unsigned top_val;
    top_val = (period > 0) ? longint'(period) - 1 : longint'(width);
    if (loop_w >= 32) return 1'b1;
    return top_val < (64'd1 << loop_w);
  endfunction

endpackage

// File: rtl/clk_ctrl_if.sv
// Control/status bundle between a controller (master) and clk_ctrl (slave).
interface clk_ctrl_if #(
  parameter int unsigned DIV_W  = 32,
  parameter int unsigned LOOP_W = 8
);
  logic [DIV_W-1:0]  div_in;
  logic              div_load;
  logic [1:0]        mode;
  logic              step;
  logic              ce;
  logic              clk_slow;
  logic              res_out;
  logic [LOOP_W-1:0] tick_cnt;

  modport master (
    output div_in, div_load, mode, step,
    input  ce, clk_slow, res_out, tick_cnt
  );

  modport slave (
    input  div_in, div_load, mode, step,
    output ce, clk_slow, res_out, tick_cnt
  );
endinterface

// File: rtl/ce_div.sv
// Loadable divide counter; tc flags the terminal count while running.
module ce_div #(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DIV_DEFAULT = 6000000
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             run,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             tc
);

  localparam logic [DIV_W-1:0] DivRst = DIV_W'(DIV_DEFAULT);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cntr;

  // Equality compare only; any restart forces cntr to 0 so it never runs past div_reg.
  assign tc = run && (cntr == div_reg);

  // Counter and divide register; a load restarts counting from 0 with the new ratio.
  always_ff @(posedge CLK) begin
    if (R) begin
      div_reg <= DivRst;
      cntr    <= '0;
    end else if (div_load) begin
      div_reg <= div_in;
      cntr    <= '0;
    end else if (!run || tc) begin
      cntr <= '0;
    end else begin
      cntr <= cntr + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clk_ctrl.sv
// Clock-enable generator with run/step/halt modes and a periodic CPU reset loop.
module clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DIV_DEFAULT = 6000000,
  parameter int unsigned LOOP_W      = 8,
  parameter int unsigned RES_PERIOD  = 16,
  parameter int unsigned RES_WIDTH   = 1
) (
  input  logic      CLK,
  input  logic      R,
  clk_ctrl_if.slave bus
);

  if (!res_cfg_ok(RES_PERIOD, RES_WIDTH) || !loop_fits(LOOP_W, RES_PERIOD, RES_WIDTH))
  begin : g_cfg_err
    $error("clk_ctrl: illegal RES_PERIOD/RES_WIDTH/LOOP_W combination");
  end

  localparam logic [LOOP_W-1:0] TickLast = LOOP_W'(RES_PERIOD == 0 ? 0 : RES_PERIOD - 1);
  localparam logic [LOOP_W-1:0] TickSat  = LOOP_W'(RES_WIDTH);

  logic              run;
  logic              step_mode;
  logic              tc;
  logic              ce_d;
  logic              ce_q;
  logic              step_q;
  logic              clk_slow_q;
  logic              res_q;
  logic [LOOP_W-1:0] tick_d;
  logic [LOOP_W-1:0] tick_q;

  assign run       = (bus.mode == MODE_RUN);
  assign step_mode = (bus.mode == MODE_STEP);

  ce_div #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_ce_div (
    .CLK      (CLK),
    .R        (R),
    .run      (run),
    .div_in   (bus.div_in),
    .div_load (bus.div_load),
    .tc       (tc)
  );

  // Mode mux: divider strobe in run, step rising edge in step, nothing in halt.
  always_comb begin
    ce_d = 1'b0;
    if (run) begin
      ce_d = tc;
    end else if (step_mode) begin
      ce_d = bus.step & ~step_q;
    end
  end

  // Reset-loop position advances once per completed ce cycle.
  always_comb begin
    tick_d = tick_q;
    if (ce_q) begin
      if (RES_PERIOD == 0) begin
        if (tick_q < TickSat) tick_d = tick_q + LOOP_W'(1);
      end else begin
        tick_d = (tick_q == TickLast) ? '0 : tick_q + LOOP_W'(1);
      end
    end
  end

  // Output and loop registers; res_out tracks the new tick value in the same edge.
  always_ff @(posedge CLK) begin
    if (R) begin
      step_q     <= 1'b0;
      ce_q       <= 1'b0;
      clk_slow_q <= 1'b0;
      tick_q     <= '0;
      res_q      <= 1'b1;
    end else begin
      step_q     <= bus.step;
      ce_q       <= ce_d;
      clk_slow_q <= clk_slow_q ^ ce_d;
      tick_q     <= tick_d;
      res_q      <= (tick_d < TickSat);
    end
  end

  assign bus.ce       = ce_q;
  assign bus.clk_slow = clk_slow_q;
  assign bus.res_out  = res_q;
  assign bus.tick_cnt = tick_q;

endmodule

// File: tb/tb_clk_ctrl.sv
// Bench for clk_ctrl: periodic (A) and one-shot (B) reset loops share one stimulus.
module tb_clk_ctrl;
  import clk_ctrl_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 8;
  localparam int unsigned DEF = 3;
  localparam int unsigned PER = 4;
  localparam int unsigned WID = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_ctrl_if #(.DIV_W(DW), .LOOP_W(LW)) bus_a ();
  clk_ctrl_if #(.DIV_W(DW), .LOOP_W(LW)) bus_b ();

  assign bus_b.div_in   = bus_a.div_in;
  assign bus_b.div_load = bus_a.div_load;
  assign bus_b.mode     = bus_a.mode;
  assign bus_b.step     = bus_a.step;

  clk_ctrl #(
    .DIV_W(DW), .DIV_DEFAULT(DEF), .LOOP_W(LW), .RES_PERIOD(PER), .RES_WIDTH(WID)
  ) dut_a (
    .CLK (clk),
    .R   (rst),
    .bus (bus_a.slave)
  );

  clk_ctrl #(
    .DIV_W(DW), .DIV_DEFAULT(DEF), .LOOP_W(LW), .RES_PERIOD(0), .RES_WIDTH(1)
  ) dut_b (
    .CLK (clk),
    .R   (rst),
    .bus (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: ce is scheduled by absolute edge number; loop outputs derive from pulse counts.
  longint m_edge = 0;
  longint m_due  = 0;
  longint m_div  = 0;
  bit     m_ce   = 1'b0;
  bit     m_prev = 1'b0;
  int     m_pulses = 0;  // ce pulses issued so far (including one currently shown)
  int     m_done   = 0;  // ce cycles that have fully elapsed

  always @(posedge clk) begin : model
    longint e;
    bit     ce_n;
    e    = m_edge + 1;
    ce_n = 1'b0;
    if (rst) begin
      m_div    <= DEF;
      m_due    <= e + DEF + 1;
      m_ce     <= 1'b0;
      m_prev   <= 1'b0;
      m_pulses <= 0;
      m_done   <= 0;
    end else begin
      if (bus_a.mode == MODE_RUN) ce_n = (e == m_due);
      else if (bus_a.mode == MODE_STEP) ce_n = bus_a.step && !m_prev;
      if (bus_a.div_load) begin
        m_div <= longint'(bus_a.div_in);
        m_due <= e + longint'(bus_a.div_in) + 1;
      end else if (bus_a.mode != MODE_RUN || e == m_due) begin
        m_due <= e + m_div + 1;
      end
      m_ce     <= ce_n;
      m_pulses <= m_pulses + int'(ce_n);
      m_done   <= m_done + int'(m_ce);
      m_prev   <= bus_a.step;
    end
    m_edge <= e;
  end

  always @(negedge clk) begin : compare
    int ta;
    int tb;
    if (m_edge > 0) begin
      ta = m_done % PER;
      tb = (m_done < 1) ? m_done : 1;
      chk("ce_a", bus_a.ce, m_ce);
      chk("ce_b", bus_b.ce, m_ce);
      chk("clk_slow_a", bus_a.clk_slow, m_pulses % 2);
      chk("clk_slow_b", bus_b.clk_slow, m_pulses % 2);
      chk("tick_a", bus_a.tick_cnt, ta);
      chk("tick_b", bus_b.tick_cnt, tb);
      chk("res_a", bus_a.res_out, ta < WID);
      chk("res_b", bus_b.res_out, tb < 1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n;
    int cnt;
    bit found;
    int ce_cyc [5];
    int ce_tick[5];
    int ce_res [5];
    int ce_slow[5];
    int ce_rb  [5];

    rst            = 1'b1;
    bus_a.div_in   = '0;
    bus_a.div_load = 1'b0;
    bus_a.mode     = MODE_RUN;
    bus_a.step     = 1'b0;
    repeat (3) cyc();
    chk("rst_ce", bus_a.ce, 0);
    chk("rst_clk_slow", bus_a.clk_slow, 0);
    chk("rst_res_a", bus_a.res_out, 1);
    chk("rst_tick_a", bus_a.tick_cnt, 0);
    chk("rst_res_b", bus_b.res_out, 1);

    // Run from reset: collect the first five ce pulses.
    rst = 1'b0;
    n   = 0;
    for (int k = 1; k <= 40 && n < 5; k++) begin
      cyc();
      if (bus_a.ce === 1'b1) begin
        ce_cyc[n]  = k;
        ce_tick[n] = int'(bus_a.tick_cnt);
        ce_res[n]  = int'(bus_a.res_out);
        ce_slow[n] = int'(bus_a.clk_slow);
        ce_rb[n]   = int'(bus_b.res_out);
        n++;
      end
    end
    chk("run_ce_count", n, 5);
    chk("first_ce_latency", ce_cyc[0], 4);
    chk("ce_period", ce_cyc[1] - ce_cyc[0], 4);
    chk("clk_slow_period", ce_cyc[2] - ce_cyc[0], 8);
    chk("tick_seq0", ce_tick[0], 0);
    chk("tick_seq1", ce_tick[1], 1);
    chk("tick_seq2", ce_tick[2], 2);
    chk("tick_seq3", ce_tick[3], 3);
    chk("tick_seq4", ce_tick[4], 0);
    chk("res_seq0", ce_res[0], 1);
    chk("res_seq1", ce_res[1], 1);
    chk("res_seq2", ce_res[2], 0);
    chk("res_seq3", ce_res[3], 0);
    chk("res_seq4", ce_res[4], 1);
    chk("slow_seq0", ce_slow[0], 1);
    chk("slow_seq1", ce_slow[1], 0);
    chk("oneshot_res0", ce_rb[0], 1);
    chk("oneshot_res1", ce_rb[1], 0);

    // div_load coinciding with the terminal count of div_reg=3.
    repeat (3) cyc();
    bus_a.div_in   = 1;
    bus_a.div_load = 1'b1;
    cyc();
    bus_a.div_load = 1'b0;
    chk("ce_on_load_tc", bus_a.ce, 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("div1_ce", bus_a.ce, i % 2);
    end

    // Reset mid-loop at tick_cnt=2, cntr=2.
    bus_a.div_in   = 3;
    bus_a.div_load = 1'b1;
    cyc();
    bus_a.div_load = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      cyc();
      if (bus_a.ce === 1'b1 && bus_a.tick_cnt == 1) found = 1'b1;
    end
    chk("find_tick1", found, 1);
    repeat (2) cyc();
    chk("pre_rst_tick", bus_a.tick_cnt, 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_tick", bus_a.tick_cnt, 0);
    chk("mid_rst_res", bus_a.res_out, 1);
    chk("mid_rst_ce", bus_a.ce, 0);
    chk("mid_rst_slow", bus_a.clk_slow, 0);
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      cyc();
      if (bus_a.ce === 1'b1) n = k;
    end
    chk("post_rst_latency", n, 4);

    // Step mode: two held rising edges give exactly two ce pulses.
    bus_a.mode = MODE_STEP;
    repeat (3) cyc();
    cnt = 0;
    for (int p = 0; p < 2; p++) begin
      bus_a.step = 1'b1;
      cyc();
      chk("step_ce_edge", bus_a.ce, 1);
      cnt += int'(bus_a.ce);
      repeat (9) begin
        cyc();
        cnt += int'(bus_a.ce);
      end
      bus_a.step = 1'b0;
      repeat (5) begin
        cyc();
        cnt += int'(bus_a.ce);
      end
    end
    chk("step_ce_total", cnt, 2);

    // Halt (both encodings) ignores step edges.
    cnt = 0;
    bus_a.mode = MODE_HALT;
    for (int k = 0; k < 30; k++) begin
      if (k == 15) bus_a.mode = 2'b11;
      bus_a.step = ~bus_a.step;
      cyc();
      cnt += int'(bus_a.ce);
    end
    bus_a.step = 1'b0;
    chk("halt_ce_total", cnt, 0);

    // div=0: ce every cycle; one-shot loop saturates.
    bus_a.mode     = MODE_RUN;
    bus_a.div_in   = 0;
    bus_a.div_load = 1'b1;
    cyc();
    bus_a.div_load = 1'b0;
    cnt = 0;
    for (int k = 0; k < 110; k++) begin
      cyc();
      cnt += int'(bus_a.ce);
    end
    chk("div0_ce_total", cnt, 110);
    chk("oneshot_tick_sat", bus_b.tick_cnt, 1);
    chk("oneshot_res_low", bus_b.res_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
